traffic_car_source: RTL

//  Vehicle-side counterpart of the traffic light controller. It queues car arrivals
//  per direction and drives the EWCar/NSCar request lines into the controller.
//  It consumes EWLite/NSLite and releases one queued car per crossing interval while
//  its direction is green. It also flags illegal light combinations.

---
 rtl/traffic_car_source_pkg.sv | 13 +
 rtl/traffic_car_source_lane.sv | 82 ++++++++
 rtl/traffic_car_source.sv | 64 ++++++
 3 files changed

// File: rtl/traffic_car_source_pkg.sv
// Shared definitions for the vehicle-side traffic model: lane state encoding and
// default queue width / crossing time.
package traffic_car_source_pkg;

    typedef enum logic {
        LANE_IDLE  = 1'b0,
        LANE_CROSS = 1'b1
    } lane_state_e;

    localparam int DEF_QW           = 4;
    localparam int DEF_CROSS_CYCLES = 3;

endpackage

// File: rtl/traffic_car_source_lane.sv
// One direction of traffic: a saturating queue counter plus a crossing FSM that
// releases one car every CROSS_CYCLES+1 edges while the lane's light is green.
module traffic_lane
    import traffic_car_source_pkg::*;
#(
    parameter int QW           = DEF_QW,
    parameter int CROSS_CYCLES = DEF_CROSS_CYCLES
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          arrive,
    input  logic          light,
    input  logic          both_green,
    output logic          car,
    output logic [QW-1:0] count,
    output logic          depart,
    output logic          overflow
);

    localparam int TW = $clog2(CROSS_CYCLES + 1);
    localparam logic [QW-1:0] QMAX  = '1;
    localparam logic [TW-1:0] TLAST = TW'(CROSS_CYCLES - 1);

    lane_state_e   state_q;
    logic [TW-1:0] timer_q;
    logic [QW-1:0] count_q;
    logic          depart_q;
    logic          ovf_q;

    logic go;
    logic at_last;
    logic dep_evt;

    // A conflicting light pair counts as red for both lanes.
    assign go      = light && !both_green;
    assign at_last = (timer_q == TLAST);
    assign dep_evt = (state_q == LANE_CROSS) && go && at_last && (count_q != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LANE_IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            depart_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            depart_q <= dep_evt;
            case (state_q)
                LANE_IDLE: begin
                    if (count_q != '0 && go) begin
                        state_q <= LANE_CROSS;
                        timer_q <= '0;
                    end
                end
                LANE_CROSS: begin
                    if (!go || at_last) begin
                        state_q <= LANE_IDLE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= LANE_IDLE;
                    timer_q <= '0;
                end
            endcase
            if (arrive && !dep_evt) begin
                if (count_q == QMAX) ovf_q <= 1'b1;
                else                 count_q <= count_q + QW'(1);
            end else if (!arrive && dep_evt) begin
                count_q <= count_q - QW'(1);
            end
        end
    end

    assign car      = (count_q != '0);
    assign count    = count_q;
    assign depart   = depart_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/traffic_car_source.sv
// Vehicle source feeding the traffic light controller: two independent lanes,
// a sticky conflict detector for both-green, and a combined overflow flag.
module traffic_car_source
    import traffic_car_source_pkg::*;
#(
    parameter int QW           = DEF_QW,
    parameter int CROSS_CYCLES = DEF_CROSS_CYCLES
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ew_arrive,
    input  logic          ns_arrive,
    input  logic          EWLite,
    input  logic          NSLite,
    output logic          EWCar,
    output logic          NSCar,
    output logic [QW-1:0] ew_count,
    output logic [QW-1:0] ns_count,
    output logic          ew_depart,
    output logic          ns_depart,
    output logic          overflow,
    output logic          conflict
);

    logic both_green;
    logic ew_ovf;
    logic ns_ovf;
    logic conflict_q;

    assign both_green = EWLite && NSLite;

    traffic_lane #(.QW(QW), .CROSS_CYCLES(CROSS_CYCLES)) u_ew (
        .clock      (clock),
        .reset_n    (reset_n),
        .arrive     (ew_arrive),
        .light      (EWLite),
        .both_green (both_green),
        .car        (EWCar),
        .count      (ew_count),
        .depart     (ew_depart),
        .overflow   (ew_ovf)
    );

    traffic_lane #(.QW(QW), .CROSS_CYCLES(CROSS_CYCLES)) u_ns (
        .clock      (clock),
        .reset_n    (reset_n),
        .arrive     (ns_arrive),
        .light      (NSLite),
        .both_green (both_green),
        .car        (NSCar),
        .count      (ns_count),
        .depart     (ns_depart),
        .overflow   (ns_ovf)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) conflict_q <= 1'b0;
        else if (both_green) conflict_q <= 1'b1;
    end

    assign overflow = ew_ovf || ns_ovf;
    assign conflict = conflict_q;

endmodule
